yolo_cmd_ctrl: RTL and testbench
================================

YOLO_CMD_CTRL -- requirements
Module: yolo_cmd_ctrl

Interface
REQ-001 Parameter BURST_BEATS, default 16: maximum beats per issued command (power of two, 1..256).
REQ-002 Parameter MAX_OUTSTANDING, default 2: maximum commands issued but not yet responded (1..15).
REQ-003 Parameter LEN_W, default 16: width of the total-beat count taken from len_reg.
REQ-004 ACLK  in  1  sole clock; all logic on the rising edge.
REQ-005 ARESETN  in  1  reset, synchronous, active-low.
REQ-006 ctrl_reg  in  32  register-file word: bit0 start, bit1 abort, bit2 done/irq clear.
REQ-007 src_addr_reg  in  32  byte start address; bits[1:0] ignored (treated as 0).
REQ-008 len_reg  in  32  total 32-bit beats; bits[LEN_W-1:0] used.
REQ-009 cmd_valid  out  1  command valid to the downstream DMA read engine.
REQ-010 cmd_ready  in  1  DMA engine accepts the command.
REQ-011 cmd_addr  out  32  command byte address.
REQ-012 cmd_len  out  8  command beats minus one.
REQ-013 resp_valid  in  1  one-cycle pulse, one per completed command.
REQ-014 status_reg  out  32  bit0 busy, bit1 done, bit2 len_err, bit3 aborted, bit4 spurious_resp, [31:16] commands completed.
REQ-015 irq  out  1  level interrupt (present only per REQ-032).

Function
REQ-016 FSM states IDLE, RUN, DRAIN, DONE; busy = 1 exactly in RUN or DRAIN.
REQ-017 Start = rising edge of ctrl_reg[0] (registered previous value); accepted only in IDLE or DONE, ignored in RUN/DRAIN.
REQ-018 On start: latch address and length, clear status bits[4:1] and completed count; len = 0 -> set len_err, go DONE next cycle, no command issued; else go RUN.
REQ-019 In RUN, cmd_valid asserts when remaining > 0 and outstanding < MAX_OUTSTANDING; cmd_len = min(remaining, BURST_BEATS) - 1.
REQ-020 Handshake: cmd_valid, cmd_addr, cmd_len held stable until cmd_valid && cmd_ready; cmd_valid never deasserted without acceptance, except on reset.
REQ-021 On acceptance: address += (cmd_len+1)*4 (32-bit wrap, no carry out), remaining -= cmd_len+1, outstanding += 1; next command may be valid the following cycle (one command per cycle max).
REQ-022 resp_valid with outstanding > 0: outstanding -= 1, completed += 1 (saturating at 0xFFFF); acceptance and response in the same cycle leave outstanding unchanged.
REQ-023 resp_valid with outstanding = 0 is ignored except setting spurious_resp.
REQ-024 RUN -> DONE when remaining = 0 and outstanding = 0 (including response and final acceptance settling); done set on entry.
REQ-025 ctrl_reg[1] high in RUN: stop issuing new commands (a command already valid completes its handshake), set aborted, go DRAIN; DRAIN -> DONE when outstanding = 0.
REQ-026 Rising edge of ctrl_reg[2] in DONE clears done and returns to IDLE; same-cycle start and clear: start wins.

Reset
REQ-027 ARESETN low at a rising edge: state IDLE, cmd_valid 0, cmd_addr 0, cmd_len 0, outstanding 0, remaining 0, status_reg 0, irq 0, edge-detect registers 0.
REQ-028 Reset mid-operation discards in-flight commands; responses arriving after reset are treated per REQ-023.
REQ-029 A start bit already high when reset releases does not start (edge register resets to 0 but first sample only arms it).

Configuration
REQ-030 Macro YOLO_CMD_IRQ_EN selects the interrupt feature.
REQ-031 Without YOLO_CMD_IRQ_EN: port irq absent; status_reg unchanged.
REQ-032 With YOLO_CMD_IRQ_EN: irq port present; irq = 1 from the cycle after entry to DONE until cleared per REQ-026, new start, or reset.

Verification
REQ-033 src 0x1000, len 40, BURST_BEATS 16, ready always 1 -> commands (0x1000,15), (0x1040,15), (0x1080,7); done and completed = 3 after third response.
REQ-034 len 0 start -> no cmd_valid, status_reg = 0x6 (done, len_err), irq 1 when enabled.
REQ-035 cmd_ready low 5 cycles on first command -> cmd_valid/addr/len constant all 5 cycles, accepted on cycle 6.
REQ-036 MAX_OUTSTANDING 2, len 48, responses withheld -> exactly 2 commands issued; third issued the cycle after first resp_valid.
REQ-037 Abort after first acceptance, len 64 -> no further commands, DRAIN until response, status_reg = 0x1000A (done, aborted, completed 1).
REQ-038 ARESETN low 1 cycle during RUN -> all outputs zero next cycle; a later resp_valid sets only spurious_resp.

Source files
------------

// File: rtl/yolo_cmd_ctrl.sv
// Command splitter: cuts one register-programmed transfer into DMA read bursts and
// tracks completions. Define YOLO_CMD_IRQ_EN to add the level interrupt output irq.
module yolo_cmd_ctrl #(
   parameter int unsigned BURST_BEATS     = 16,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter int unsigned LEN_W           = 16
) (
   input  logic        ACLK,
   input  logic        ARESETN,
   input  logic [31:0] ctrl_reg,
   input  logic [31:0] src_addr_reg,
   input  logic [31:0] len_reg,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [31:0] cmd_addr,
   output logic [7:0]  cmd_len,
   input  logic        resp_valid,
   output logic [31:0] status_reg
`ifdef YOLO_CMD_IRQ_EN
   ,
   output logic        irq
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_e;

   state_e             state_q;
   logic               start_prev_q;
   logic               clr_prev_q;
   logic               armed_q;
   logic [31:0]        addr_q;
   logic [LEN_W-1:0]   rem_q;
   logic [3:0]         out_q;
   logic               cmd_valid_q;
   logic [31:0]        cmd_addr_q;
   logic [7:0]         cmd_len_q;
   logic               done_q;
   logic               len_err_q;
   logic               aborted_q;
   logic               spur_q;
   logic [15:0]        done_cnt_q;
   logic               irq_q;

   logic               start_edge;
   logic               clr_edge;
   logic               accept;
   logic               resp_ok;
   logic               hold;
   logic               drained;
   logic               can_issue;
   logic               len_zero;
   logic [8:0]         beats_acc;
   logic [8:0]         next_beats;
   logic [7:0]         next_len;
   logic [31:0]        addr_after;
   logic [LEN_W-1:0]   rem_after;
   logic [3:0]         out_after;
   logic               unused_ok;

   // The first clock after reset only arms the edge detectors, so a bit already
   // high when reset releases is never mistaken for a rising edge.
   always_comb begin
      start_edge = armed_q & ctrl_reg[0] & ~start_prev_q;
      clr_edge   = armed_q & ctrl_reg[2] & ~clr_prev_q;
      accept     = cmd_valid_q & cmd_ready;
      hold       = cmd_valid_q & ~cmd_ready;
      resp_ok    = resp_valid & (out_q != 4'd0);
      len_zero   = (len_reg[LEN_W-1:0] == '0);
      beats_acc  = {1'b0, cmd_len_q} + 9'd1;

      addr_after = addr_q;
      rem_after  = rem_q;
      if (accept) begin
         addr_after = addr_q + {21'd0, beats_acc, 2'b00};
         rem_after  = rem_q - LEN_W'(beats_acc);
      end
      out_after = out_q + {3'd0, accept} - {3'd0, resp_ok};

      if (32'(rem_after) >= BURST_BEATS) next_beats = 9'(BURST_BEATS);
      else                               next_beats = 9'(rem_after);
      next_len  = 8'(next_beats - 9'd1);
      can_issue = (rem_after != '0) && (32'(out_after) < MAX_OUTSTANDING);
      drained   = (out_after == 4'd0) && !hold;
   end

   // NOTE: every register in this block uses <= so all branches see the
   // values from before the edge; the reset branch is synchronous on purpose.
   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         state_q      <= ST_IDLE;
         start_prev_q <= 1'b0;
         clr_prev_q   <= 1'b0;
         armed_q      <= 1'b0;
         addr_q       <= '0;
         rem_q        <= '0;
         out_q        <= '0;
         cmd_valid_q  <= 1'b0;
         cmd_addr_q   <= '0;
         cmd_len_q    <= '0;
         done_q       <= 1'b0;
         len_err_q    <= 1'b0;
         aborted_q    <= 1'b0;
         spur_q       <= 1'b0;
         done_cnt_q   <= '0;
         irq_q        <= 1'b0;
      end else begin
         start_prev_q <= ctrl_reg[0];
         clr_prev_q   <= ctrl_reg[2];
         armed_q      <= 1'b1;
         addr_q       <= addr_after;
         rem_q        <= rem_after;
         out_q        <= out_after;
         irq_q        <= 1'b0;
         if (!hold) cmd_valid_q <= 1'b0;
         if (resp_ok && done_cnt_q != 16'hFFFF) done_cnt_q <= done_cnt_q + 16'd1;
         if (resp_valid && out_q == 4'd0) spur_q <= 1'b1;

         if (start_edge && (state_q == ST_IDLE || state_q == ST_DONE)) begin
            addr_q     <= {src_addr_reg[31:2], 2'b00};
            rem_q      <= len_reg[LEN_W-1:0];
            done_q     <= len_zero;
            len_err_q  <= len_zero;
            aborted_q  <= 1'b0;
            spur_q     <= 1'b0;
            done_cnt_q <= '0;
            state_q    <= len_zero ? ST_DONE : ST_RUN;
         end else begin
            unique case (state_q)
               ST_IDLE: ;
               ST_RUN: begin
                  if (ctrl_reg[1]) begin
                     aborted_q <= 1'b1;
                     state_q   <= ST_DRAIN;
                  end else if (rem_after == '0 && drained) begin
                     done_q  <= 1'b1;
                     state_q <= ST_DONE;
                  end else if (!hold && can_issue) begin
                     cmd_valid_q <= 1'b1;
                     cmd_addr_q  <= addr_after;
                     cmd_len_q   <= next_len;
                  end
               end
               ST_DRAIN: begin
                  if (drained) begin
                     done_q  <= 1'b1;
                     state_q <= ST_DONE;
                  end
               end
               ST_DONE: begin
                  if (clr_edge) begin
                     done_q  <= 1'b0;
                     state_q <= ST_IDLE;
                  end else begin
                     irq_q <= 1'b1;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign cmd_valid  = cmd_valid_q;
   assign cmd_addr   = cmd_addr_q;
   assign cmd_len    = cmd_len_q;
   assign status_reg = {done_cnt_q, 11'd0, spur_q, aborted_q, len_err_q, done_q,
                        (state_q == ST_RUN) || (state_q == ST_DRAIN)};

`ifdef YOLO_CMD_IRQ_EN
   assign irq = irq_q;
   assign unused_ok = ^{ctrl_reg[31:3], src_addr_reg[1:0], len_reg};
`else
   assign unused_ok = ^{ctrl_reg[31:3], src_addr_reg[1:0], len_reg, irq_q};
`endif

endmodule

// File: tb/tb_yolo_cmd_ctrl.sv
// Directed self-checking bench for yolo_cmd_ctrl with default parameters
// (BURST_BEATS 16, MAX_OUTSTANDING 2); irq checks apply when YOLO_CMD_IRQ_EN is set.
module tb_yolo_cmd_ctrl;

   logic        ACLK;
   logic        ARESETN;
   logic [31:0] ctrl_reg;
   logic [31:0] src_addr_reg;
   logic [31:0] len_reg;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_addr;
   logic [7:0]  cmd_len;
   logic        resp_valid;
   logic [31:0] status_reg;
`ifdef YOLO_CMD_IRQ_EN
   logic        irq;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] rec_addr[$];
   logic [7:0]  rec_len[$];

   yolo_cmd_ctrl dut (
      .ACLK        (ACLK),
      .ARESETN     (ARESETN),
      .ctrl_reg    (ctrl_reg),
      .src_addr_reg(src_addr_reg),
      .len_reg     (len_reg),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_addr    (cmd_addr),
      .cmd_len     (cmd_len),
      .resp_valid  (resp_valid),
      .status_reg  (status_reg)
`ifdef YOLO_CMD_IRQ_EN
      ,
      .irq         (irq)
`endif
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic do_start(input logic [31:0] addr, input logic [31:0] len);
      src_addr_reg = addr;
      len_reg      = len;
      ctrl_reg     = 32'h1;
      tick();
      ctrl_reg     = 32'h0;
   endtask

   task automatic pulse_resp();
      resp_valid = 1'b1;
      tick();
      resp_valid = 1'b0;
   endtask

   // Accepts every offered command and answers each one a cycle later until done.
   task automatic run_to_done(input int pend0, input int max_cycles);
      int pend = pend0;
      for (int c = 0; c < max_cycles; c++) begin
         if (status_reg[1]) break;
         resp_valid = (pend > 0);
         if (pend > 0) pend--;
         if (cmd_valid && cmd_ready) begin
            rec_addr.push_back(cmd_addr);
            rec_len.push_back(cmd_len);
            pend++;
         end
         tick();
      end
      resp_valid = 1'b0;
      check("done_reached", {31'd0, status_reg[1]}, 32'd1);
   endtask

   initial begin
      ARESETN      = 1'b0;
      ctrl_reg     = '0;
      src_addr_reg = '0;
      len_reg      = '0;
      cmd_ready    = 1'b1;
      resp_valid   = 1'b0;
      tick();
      tick();
      check("rst_status", status_reg, 32'h0);
      check("rst_valid", {31'd0, cmd_valid}, 32'd0);
      check("rst_addr", cmd_addr, 32'h0);
      check("rst_len", {24'd0, cmd_len}, 32'd0);
      ARESETN = 1'b1;
      tick();
      tick();

      // Three bursts: 16 + 16 + 8 beats, low address bits ignored.
      rec_addr.delete();
      rec_len.delete();
      do_start(32'h0000_1003, 32'd40);
      check("run_busy", status_reg, 32'h1);
      run_to_done(0, 60);
      check("b3_count", rec_addr.size(), 32'd3);
      if (rec_addr.size() == 3) begin
         check("b3_addr0", rec_addr[0], 32'h1000);
         check("b3_len0", {24'd0, rec_len[0]}, 32'd15);
         check("b3_addr1", rec_addr[1], 32'h1040);
         check("b3_len1", {24'd0, rec_len[1]}, 32'd15);
         check("b3_addr2", rec_addr[2], 32'h1080);
         check("b3_len2", {24'd0, rec_len[2]}, 32'd7);
      end
      check("b3_status", status_reg, 32'h0003_0002);
      tick();
`ifdef YOLO_CMD_IRQ_EN
      check("b3_irq", {31'd0, irq}, 32'd1);
`endif

      // Clearing done returns to idle and keeps the completion count.
      ctrl_reg = 32'h4;
      tick();
      ctrl_reg = 32'h0;
      check("clr_status", status_reg, 32'h0003_0000);
`ifdef YOLO_CMD_IRQ_EN
      check("clr_irq", {31'd0, irq}, 32'd0);
`endif

      // Zero-length start.
      do_start(32'h0000_2000, 32'd0);
      check("len0_status", status_reg, 32'h6);
      for (int i = 0; i < 4; i++) begin
         check("len0_novalid", {31'd0, cmd_valid}, 32'd0);
         tick();
      end
`ifdef YOLO_CMD_IRQ_EN
      check("len0_irq", {31'd0, irq}, 32'd1);
`endif

      // Backpressure: command held stable for 5 cycles, accepted on the 6th.
      cmd_ready = 1'b0;
      do_start(32'h0000_2000, 32'd8);
      tick();
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", {31'd0, cmd_valid}, 32'd1);
         check("bp_addr", cmd_addr, 32'h2000);
         check("bp_len", {24'd0, cmd_len}, 32'd7);
         tick();
      end
      cmd_ready = 1'b1;
      check("bp_valid6", {31'd0, cmd_valid}, 32'd1);
      tick();
      check("bp_accepted", {31'd0, cmd_valid}, 32'd0);
      pulse_resp();
      check("bp_status", status_reg, 32'h0001_0002);

      // Outstanding limit with responses withheld.
      rec_addr.delete();
      rec_len.delete();
      do_start(32'h0000_0000, 32'd48);
      for (int i = 0; i < 10; i++) begin
         if (cmd_valid && cmd_ready) begin
            rec_addr.push_back(cmd_addr);
            rec_len.push_back(cmd_len);
         end
         tick();
      end
      check("mo_issued", rec_addr.size(), 32'd2);
      check("mo_stalled", {31'd0, cmd_valid}, 32'd0);
      pulse_resp();
      check("mo_third_valid", {31'd0, cmd_valid}, 32'd1);
      check("mo_third_addr", cmd_addr, 32'h80);
      check("mo_third_len", {24'd0, cmd_len}, 32'd15);
      run_to_done(1, 40);
      check("mo_total", rec_addr.size(), 32'd3);
      check("mo_status", status_reg, 32'h0003_0002);

      // Abort raised on the cycle the first command is accepted.
      do_start(32'h0000_4000, 32'd64);
      tick();
      check("ab_first_valid", {31'd0, cmd_valid}, 32'd1);
      ctrl_reg = 32'h2;
      tick();
      ctrl_reg = 32'h0;
      for (int i = 0; i < 3; i++) begin
         check("ab_novalid", {31'd0, cmd_valid}, 32'd0);
         check("ab_drain", status_reg, 32'h9);
         tick();
      end
      pulse_resp();
      check("ab_status", status_reg, 32'h0001_000A);

      // Reset in the middle of a run, with start held high across release.
      do_start(32'h0000_5000, 32'd64);
      tick();
      tick();
      ctrl_reg = 32'h1;
      ARESETN  = 1'b0;
      tick();
      check("mr_valid", {31'd0, cmd_valid}, 32'd0);
      check("mr_addr", cmd_addr, 32'h0);
      check("mr_len", {24'd0, cmd_len}, 32'd0);
      check("mr_status", status_reg, 32'h0);
      ARESETN = 1'b1;
      tick();
      tick();
      tick();
      check("mr_nostart", status_reg, 32'h0);
      check("mr_nostart_valid", {31'd0, cmd_valid}, 32'd0);
      ctrl_reg = 32'h0;
      pulse_resp();
      check("mr_spurious", status_reg, 32'h10);
`ifdef YOLO_CMD_IRQ_EN
      check("mr_irq", {31'd0, irq}, 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
